fetch_stage_ctrl: RTL

FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

---
 rtl/fetch_stage_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fetch_stage_ctrl.sv
// Instruction fetch controller: drives the I-memory request/address, registers the
// fetched word for decode, parks one acked word while decode stalls, and handles redirects.
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter logic [31:0] NOP_WORD = 32'h00000000
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        JumpTaken,
   input  logic [31:0] JumpTarget,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] InstructionOut,
   output logic [31:0] PC4Out,
   output logic        ValidOut
);

   // state | meaning
   // IDLE  | single cycle after reset release, no request yet
   // REQ   | request outstanding at PC; an ack delivers or parks the word
   // HOLD  | acked word parked in buffer while decode stalls, request dropped
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic [31:0] buf_pc4_q, buf_pc4_d;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   assign redirect = BranchTaken | JumpTaken;
   assign target   = BranchTaken ? BranchTarget : JumpTarget;
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_d       = req_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      buf_instr_d = buf_instr_q;
      buf_pc4_d   = buf_pc4_q;

      if (redirect) begin
         // Redirect beats stall and drops both the parked word and any same-cycle ack.
         pc_d        = target & ~32'd3;
         instr_d     = NOP_WORD;
         valid_d     = 1'b0;
         buf_instr_d = NOP_WORD;
         buf_pc4_d   = 32'd0;
         state_d     = REQ;
         req_d       = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
               req_d   = 1'b1;
            end
            REQ: begin
               if (IMemAck) begin
                  if (Stall) begin
                     buf_instr_d = IMemData;
                     buf_pc4_d   = pc_plus4;
                     state_d     = HOLD;
                     req_d       = 1'b0;
                  end else begin
                     instr_d = IMemData;
                     pc4_d   = pc_plus4;
                     valid_d = 1'b1;
                     pc_d    = pc_plus4;
                  end
               end else if (!Stall) begin
                  instr_d = NOP_WORD;
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!Stall) begin
                  instr_d     = buf_instr_q;
                  pc4_d       = buf_pc4_q;
                  valid_d     = 1'b1;
                  pc_d        = pc_plus4;
                  buf_instr_d = NOP_WORD;
                  buf_pc4_d   = 32'd0;
                  state_d     = REQ;
                  req_d       = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_q       <= 1'b0;
         instr_q     <= NOP_WORD;
         pc4_q       <= 32'd0;
         valid_q     <= 1'b0;
         buf_instr_q <= NOP_WORD;
         buf_pc4_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_q       <= req_d;
         instr_q     <= instr_d;
         pc4_q       <= pc4_d;
         valid_q     <= valid_d;
         buf_instr_q <= buf_instr_d;
         buf_pc4_q   <= buf_pc4_d;
      end
   end

   assign IMemReq        = req_q;
   assign IMemAddr       = pc_q;
   assign InstructionOut = instr_q;
   assign PC4Out         = pc4_q;
   assign ValidOut       = valid_q;

endmodule
